// File: rtl/reg_c_read_port.sv
// C-register file (2^AW x DW) with a two-operand registered read port and valid/stall handshake.
// Optional write-to-read forwarding on same-edge collisions: define REG_C_BYPASS_EN.
module reg_c_read_port #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          out_valid,
  input  logic          out_stall,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_regs [DEPTH];
  logic          r_out_valid;
  logic [DW-1:0] r_out_a;
  logic [DW-1:0] r_out_b;
  logic          w_rd_ready;
  logic [DW-1:0] w_read_a;
  logic [DW-1:0] w_read_b;

  // The output slot frees up whenever it is empty or the consumer is taking it.
  assign w_rd_ready = !r_out_valid | !out_stall;

`ifdef REG_C_BYPASS_EN
  assign w_read_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : r_regs[rd_addr_a];
  assign w_read_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : r_regs[rd_addr_b];
`else
  assign w_read_a = r_regs[rd_addr_a];
  assign w_read_b = r_regs[rd_addr_b];
`endif

  // Writes commit regardless of the read handshake, so a stalled consumer never blocks write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else if (w_rd_ready) begin
      r_out_valid <= rd_req;
      if (rd_req) begin
        r_out_a <= w_read_a;
        r_out_b <= w_read_b;
      end
    end
  end

  assign rd_ready  = w_rd_ready;
  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;

endmodule

// File: tb/tb_reg_c_read_port.sv
// Directed self-checking bench for reg_c_read_port; each scenario task checks its own results.
// Expected collision value follows REG_C_BYPASS_EN when the bench is built with it.
module tb_reg_c_read_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       rd_ready;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic       out_valid;
  logic       out_stall;
  logic [7:0] out_a;
  logic [7:0] out_b;

  int errors = 0;
  int checks = 0;

  reg_c_read_port #(.DW(8), .AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .out_valid (out_valid),
    .out_stall (out_stall),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_req    = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    out_stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    tick();
    rd_req = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL reset_prefetch: valid=%b a=%h, required valid=1 a=5a", out_valid, out_a);
    end
    out_stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00 || rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_async: valid=%b a=%h b=%h ready=%b, required 0/00/00/1",
               out_valid, out_a, out_b, rd_ready);
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hFF;
    rd_req = 1'b1; rd_addr_a = 3'd4; rd_addr_b = 3'd4;
    tick();
    checks++;
    if (out_valid !== 1'b0 || rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_held: valid=%b ready=%b, required valid=0 ready=1", out_valid, rd_ready);
    end
    idle_inputs();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      tick();
      exp = 8'h00;
      checks++;
      if (out_valid !== 1'b1 || out_a !== exp || out_b !== exp) begin
        errors++;
        $display("[TB] FAIL reset_clear r%0d: valid=%b a=%h b=%h, required valid=1 a=%h b=%h",
                 i, out_valid, out_a, out_b, exp, exp);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    tick();
    rd_req = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 8'hA5 || out_b !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL write_read: valid=%b a=%h b=%h, required valid=1 a=a5 b=a5", out_valid, out_a, out_b);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_a;
`ifdef REG_C_BYPASS_EN
    exp_a = 8'h7E;
`else
    exp_a = 8'h11;
`endif
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h11;
    tick();
    wr_data = 8'h7E;
    rd_req = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd2;
    tick();
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== exp_a || out_b !== 8'h00) begin
      errors++;
      $display("[TB] FAIL collision: valid=%b a=%h b=%h, required valid=1 a=%h b=00", out_valid, out_a, out_b, exp_a);
    end
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    tick();
    rd_req = 1'b0;
    checks++;
    if (out_a !== 8'h7E || out_b !== 8'h7E) begin
      errors++;
      $display("[TB] FAIL collision_followup: a=%h b=%h, required a=7e b=7e", out_a, out_b);
    end
  endtask

  task automatic test_stall();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h22;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 8'h22) begin
      errors++;
      $display("[TB] FAIL stall_fetch: valid=%b a=%h, required valid=1 a=22", out_valid, out_a);
    end
    out_stall = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h33;
    #1;
    checks++;
    if (rd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_ready: ready=%b, required 0", rd_ready);
    end
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_a !== 8'h22 || out_b !== 8'h22 || rd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: valid=%b a=%h b=%h ready=%b, required 1/22/22/0",
                 k, out_valid, out_a, out_b, rd_ready);
      end
      tick();
    end
    out_stall = 1'b0;
    #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready: ready=%b, required 1", rd_ready);
    end
    tick();
    rd_req = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 8'h33 || out_b !== 8'h33) begin
      errors++;
      $display("[TB] FAIL stall_release: valid=%b a=%h b=%h, required valid=1 a=33 b=33", out_valid, out_a, out_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      tick();
      exp_a = 8'(8'h10 + i);
      exp_b = 8'(8'h17 - i);
      checks++;
      if (out_valid !== 1'b1 || out_a !== exp_a || out_b !== exp_b) begin
        errors++;
        $display("[TB] FAIL back_to_back%0d: valid=%b a=%h b=%h, required valid=1 a=%h b=%h",
                 i, out_valid, out_a, out_b, exp_a, exp_b);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_idle();
    rd_req = 1'b0; out_stall = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_a !== 8'h17 || out_b !== 8'h10 || rd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle: valid=%b a=%h b=%h ready=%b, required 0/17/10/1", out_valid, out_a, out_b, rd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_stall();
    test_back_to_back();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_c_read_port.md
# reg_c_read_port

Register-file read side for the C-register write path. It holds the 8-entry × 8-bit register array that the write-C data mux output commits into. It serves two operand reads per request through a one-entry output pipeline register with a valid/stall handshake toward the execute stage. It sits between the write-back mux and the ALU operand inputs.

## Interface

**Parameters**
- `DW`, 8, data width of each register and read/write data.
- `AW`, 3, register address width; array depth is 2^AW.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: commit `wr_data` to `wr_addr` on this edge.
- `wr_addr`, input, AW: write register index.
- `wr_data`, input, DW: write data, driven by the write-C mux output.
- `rd_req`, input, 1: operand read request valid.
- `rd_ready`, output, 1: request accepted this cycle when `rd_req & rd_ready`.
- `rd_addr_a`, input, AW: operand A register index.
- `rd_addr_b`, input, AW: operand B register index.
- `out_valid`, output, 1: `out_a`/`out_b` hold a fetched operand pair.
- `out_stall`, input, 1: consumer cannot take the current output.
- `out_a`, output, DW: registered operand A.
- `out_b`, output, DW: registered operand B.

## Operation

- Array: 2^AW registers of DW bits. All registers are writable, including index 0, which has no hardwired zero.
- Write: on a rising edge with `wr_en` = 1, `regs[wr_addr] <= wr_data`. A write is independent of the read handshake and is never blocked by stall.
- `rd_ready = !out_valid | !out_stall`. This is combinational and has no dependence on `rd_req`.
- Accept (`rd_req & rd_ready`) at an edge:
  - `out_a <= read(rd_addr_a)`.
  - `out_b <= read(rd_addr_b)`.
  - `out_valid <= 1`.
- Ready but no request at an edge: `out_valid <= 0`. `out_a`/`out_b` hold their last values.
- Stall (`out_valid & out_stall`): `out_valid`, `out_a` and `out_b` all hold.
  - Outputs are a snapshot. A later write to the same register does not alter a held `out_a`/`out_b`.
- `read(x)`: defined by the bypass configuration (see Configuration).
- `rd_addr_a == rd_addr_b` is legal. Both outputs receive the identical value.
- Reset (asserted at any time, including mid-stall):
  - All registers clear to 0.
  - `out_valid` = 0, `out_a` = 0, `out_b` = 0.
  - `rd_ready` = 1 while reset is asserted.
  - Writes and requests presented while reset is asserted are discarded.

## Timing

- Read latency: 1 cycle. A request accepted at edge N is visible on `out_*` after edge N, with `out_valid` = 1.
- Write-to-array latency: 1 edge. A write at edge N is readable from the array by a request accepted at edge N+1.
- Throughput: one request per cycle when `out_stall` = 0.
- With stall held, a new request is accepted on the same edge where `out_stall` deasserts. There is no bubble.
- All outputs except `rd_ready` are registered.

## Configuration

- `REG_C_BYPASS_EN` defined:
  - If `wr_en` and `wr_addr == rd_addr_x` on the accepting edge, `read(x)` returns `wr_data`.
  - This is write-to-read forwarding, so the new value is returned.
  - It applies independently to port A and port B.
- `REG_C_BYPASS_EN` undefined:
  - `read(x)` returns `regs[rd_addr_x]`, the pre-write value, on a same-edge collision.
  - The new value is seen starting with the next request.

## Test plan

1. **Reset values:** assert `reset` mid-cycle with `out_valid` = 1 → all outputs are immediately 0 and `rd_ready` = 1. After release, reading r0..r7 returns 0x00.
2. **Write then read:**
   - Stimulus: write r3 = 0xA5 at edge 1; request A = 3, B = 3 at edge 2.
   - Required response: after edge 2, `out_a` = `out_b` = 0xA5 and `out_valid` = 1.
3. **Same-edge collision:**
   - Stimulus: r5 = 0x11; on one edge, write r5 = 0x7E and request A = 5, B = 2.
   - Required response with the macro: `out_a` = 0x7E.
   - Required response without the macro: `out_a` = 0x11, and a follow-up read returns 0x7E.
4. **Stall hold with snapshot:**
   - Stimulus: fetch r1 = 0x22 and assert `out_stall`; write r1 = 0x33 while stalled; present a new request meanwhile.
   - Required response while stalled: `rd_ready` = 0 and `out_a` stays 0x22.
   - Required response when the stall drops: the pending request is accepted on that edge and returns 0x33.
5. **Back-to-back throughput:**
   - Stimulus: 8 consecutive requests to r0..r7 (preloaded 0x10..0x17) with `out_stall` = 0.
   - Required response: 8 consecutive valid outputs of 0x10..0x17, with no gaps.
6. **Idle:** with `out_stall` = 0 and `rd_req` = 0 after one fetch → `out_valid` drops to 0 the next edge and `out_a`/`out_b` are unchanged.
